// File: rtl/norm_seq.sv
// norm_seq: sequences the two-phase normalization unit.
//
// A job of N rows runs in three phases:
//   ACC : read psum rows 0..N-1 on consecutive cycles; each row is sent to
//         the normalizer as an acc beat one cycle after its read.
//   GAP : ACC_GAP quiet cycles so the normalizer's sum-FIFO write lands.
//   DIV : re-read each row (one read every 1+DIV_GAP cycles), send it as a
//         div beat, then write the normalizer's answer to output memory at
//         the same row address. Read, div beat and write for successive rows
//         overlap in flight but stay strictly in order.
// A one-cycle DONE state follows, then IDLE.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, num_rows   one-cycle job request with row count (clamped to MAX_ROWS)
//   busy, done        job in progress / one-cycle completion pulse
//   pmem_rd/addr/data psum memory read port (data valid cycle after rd)
//   acc, div, sfp_in  beats and row data to the normalizer
//   sfp_out           normalized row, valid cycle after a div beat
//   omem_wr/addr/data output memory write port
//   dbg_state         current FSM state, for observation only
//
// Handshake: no back-pressure. Every strobe (pmem_rd, acc, div, omem_wr) is
// a single-cycle event that the receiver must accept in that cycle; data
// buses carry zero whenever their strobe is low.
module norm_seq #(
    parameter int ROW_W    = 128,
    parameter int ADDR_W   = 4,
    parameter int MAX_ROWS = 16,
    parameter int ACC_GAP  = 3,
    parameter int DIV_GAP  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        num_rows,
    output logic              busy,
    output logic              done,
    output logic              pmem_rd,
    output logic [ADDR_W-1:0] pmem_addr,
    input  logic [ROW_W-1:0]  pmem_data,
    output logic              acc,
    output logic              div,
    output logic [ROW_W-1:0]  sfp_in,
    input  logic [ROW_W-1:0]  sfp_out,
    output logic              omem_wr,
    output logic [ADDR_W-1:0] omem_addr,
    output logic [ROW_W-1:0]  omem_data,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC  = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int CNT_W = 5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [7:0]        pace_q, pace_d;
    logic              acc_q, acc_d;
    logic              div_q, div_d;
    logic [ADDR_W-1:0] div_addr_q, div_addr_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic              rd;
    logic [ADDR_W-1:0] rd_addr;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        row_cnt_d  = row_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pace_d     = pace_q;
        acc_d      = 1'b0;
        div_d      = 1'b0;
        div_addr_d = div_addr_q;
        // The write stage always trails the div beat by one cycle.
        wr_d       = div_q;
        wr_addr_d  = div_addr_q;
        rd         = 1'b0;
        rd_addr    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_cnt_d = '0;
                    gap_cnt_d = '0;
                    pace_d    = '0;
                    if (num_rows == 5'd0) begin
                        n_d     = '0;
                        state_d = S_DONE;
                    end else if (num_rows > 5'(MAX_ROWS)) begin
                        n_d     = CNT_W'(MAX_ROWS);
                        state_d = S_ACC;
                    end else begin
                        n_d     = num_rows;
                        state_d = S_ACC;
                    end
                end
            end

            S_ACC: begin
                rd      = 1'b1;
                rd_addr = ADDR_W'(row_cnt_q);
                acc_d   = 1'b1;
                if (row_cnt_q == n_q - 5'd1) begin
                    row_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    row_cnt_d = row_cnt_q + 5'd1;
                end
            end

            // GAP is entered on the cycle of the last acc beat, so it lasts
            // ACC_GAP+1 cycles to leave ACC_GAP quiet cycles after that beat.
            S_GAP: begin
                if (gap_cnt_q == 8'(ACC_GAP)) begin
                    pace_d  = '0;
                    state_d = S_DIV;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            S_DIV: begin
                if (row_cnt_q != n_q) begin
                    if (pace_q == 8'd0) begin
                        rd         = 1'b1;
                        rd_addr    = ADDR_W'(row_cnt_q);
                        div_d      = 1'b1;
                        div_addr_d = ADDR_W'(row_cnt_q);
                        row_cnt_d  = row_cnt_q + 5'd1;
                        pace_d     = 8'(DIV_GAP);
                    end else begin
                        pace_d = pace_q - 8'd1;
                    end
                end else if (wr_q && !div_q) begin
                    // All reads issued and the final write is on the bus now.
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            row_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            pace_q     <= '0;
            acc_q      <= 1'b0;
            div_q      <= 1'b0;
            div_addr_q <= '0;
            wr_q       <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            row_cnt_q  <= row_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pace_q     <= pace_d;
            acc_q      <= acc_d;
            div_q      <= div_d;
            div_addr_q <= div_addr_d;
            wr_q       <= wr_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    assign busy      = (state_q == S_ACC) || (state_q == S_GAP) || (state_q == S_DIV);
    assign done      = (state_q == S_DONE);
    assign pmem_rd   = rd;
    assign pmem_addr = rd_addr;
    assign acc       = acc_q;
    assign div       = div_q;
    assign sfp_in    = (acc_q || div_q) ? pmem_data : '0;
    assign omem_wr   = wr_q;
    assign omem_addr = wr_q ? wr_addr_q : '0;
    assign omem_data = wr_q ? sfp_out : '0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_norm_seq.sv
// Bench for norm_seq. A reference model predicts, from a job's start cycle
// and row count, every read, acc beat, div beat, output write and the done
// pulse, and queues them; a monitor compares DUT activity against the queues.
module tb_norm_seq;

    localparam int ROW_W = 128;
    localparam int ADDR_W = 4;
    localparam int MAX_ROWS = 16;
    localparam int ACC_GAP = 3;
    localparam int DIV_GAP = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [4:0]        num_rows = '0;
    logic              busy, done, pmem_rd, acc, div, omem_wr;
    logic [ADDR_W-1:0] pmem_addr, omem_addr;
    logic [ROW_W-1:0]  pmem_data, sfp_in, sfp_out, omem_data;
    logic [2:0]        dbg_state;

    norm_seq #(
        .ROW_W(ROW_W), .ADDR_W(ADDR_W), .MAX_ROWS(MAX_ROWS),
        .ACC_GAP(ACC_GAP), .DIV_GAP(DIV_GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .busy(busy), .done(done), .pmem_rd(pmem_rd), .pmem_addr(pmem_addr),
        .pmem_data(pmem_data), .acc(acc), .div(div), .sfp_in(sfp_in),
        .sfp_out(sfp_out), .omem_wr(omem_wr), .omem_addr(omem_addr),
        .omem_data(omem_data), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory and normalizer models ----------------
    logic [ROW_W-1:0] mem [MAX_ROWS];

    function automatic logic [ROW_W-1:0] rnd_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in for the normalizer's divide result: any fixed, data-dependent map.
    function automatic logic [ROW_W-1:0] norm(input logic [ROW_W-1:0] x);
        logic [ROW_W-1:0] r;
        r = {x[63:0], x[127:64]} ^ {8{16'h5A3C}};
        return r;
    endfunction

    always @(posedge clk) begin
        pmem_data <= pmem_rd ? mem[pmem_addr] : rnd_row();
        sfp_out   <= div ? norm(sfp_in) : rnd_row();
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int               cyc;
        logic [3:0]       addr;
        logic [ROW_W-1:0] data;
    } ev_t;

    ev_t exp_rd_q[$];
    ev_t exp_acc_q[$];
    ev_t exp_div_q[$];
    ev_t exp_wr_q[$];
    ev_t exp_done_q[$];

    int checks = 0;
    int errors = 0;

    bit job_active = 0;
    int job_s = 0;
    int job_l = 0;
    bit done_seen = 0;
    int done_cyc = 0;

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int latency(input int n);
        if (n == 0) return 1;
        return 1 + n + 1 + ACC_GAP + (n - 1) * (1 + DIV_GAP) + 2 + 1;
    endfunction

    // Reference schedule of a job started (start high) in cycle s.
    task automatic model_job(input int s, input int n);
        ev_t e;
        int r;
        for (int i = 0; i < n; i++) begin
            e.cyc = s + 1 + i; e.addr = 4'(i); e.data = '0;        exp_rd_q.push_back(e);
            e.cyc = s + 2 + i; e.addr = '0;    e.data = mem[i];    exp_acc_q.push_back(e);
        end
        for (int j = 0; j < n; j++) begin
            r = s + n + 2 + ACC_GAP + j * (1 + DIV_GAP);
            e.cyc = r;     e.addr = 4'(j); e.data = '0;            exp_rd_q.push_back(e);
            e.cyc = r + 1; e.addr = '0;    e.data = mem[j];        exp_div_q.push_back(e);
            e.cyc = r + 2; e.addr = 4'(j); e.data = norm(mem[j]);  exp_wr_q.push_back(e);
        end
        e.cyc = s + latency(n); e.addr = '0; e.data = '0;
        exp_done_q.push_back(e);
    endtask

    task automatic flush_model();
        exp_rd_q.delete(); exp_acc_q.delete(); exp_div_q.delete();
        exp_wr_q.delete(); exp_done_q.delete();
        job_active = 0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ev_t e;
        bit exp_busy;
        check("acc_div_overlap", {127'd0, acc && div}, '0);
        if (!acc && !div) check("sfp_in_idle_zero", sfp_in, '0);
        exp_busy = job_active && (cyc > job_s) && (cyc < job_s + job_l);
        check("busy", {127'd0, busy}, {127'd0, exp_busy});

        if (pmem_rd) begin
            if (exp_rd_q.size() == 0) check("pmem_rd_unexpected", 1, 0);
            else begin
                e = exp_rd_q.pop_front();
                check("pmem_rd_cycle", cyc, e.cyc);
                check("pmem_addr", {124'd0, pmem_addr}, {124'd0, e.addr});
            end
        end
        if (acc) begin
            if (exp_acc_q.size() == 0) check("acc_unexpected", 1, 0);
            else begin
                e = exp_acc_q.pop_front();
                check("acc_cycle", cyc, e.cyc);
                check("acc_sfp_in", sfp_in, e.data);
            end
        end
        if (div) begin
            if (exp_div_q.size() == 0) check("div_unexpected", 1, 0);
            else begin
                e = exp_div_q.pop_front();
                check("div_cycle", cyc, e.cyc);
                check("div_sfp_in", sfp_in, e.data);
            end
        end
        if (omem_wr) begin
            if (exp_wr_q.size() == 0) check("omem_wr_unexpected", 1, 0);
            else begin
                e = exp_wr_q.pop_front();
                check("omem_wr_cycle", cyc, e.cyc);
                check("omem_addr", {124'd0, omem_addr}, {124'd0, e.addr});
                check("omem_data", omem_data, e.data);
            end
        end
        if (done) begin
            if (exp_done_q.size() == 0) check("done_unexpected", 1, 0);
            else begin
                e = exp_done_q.pop_front();
                check("done_cycle", cyc, e.cyc);
            end
            done_seen = 1;
            done_cyc  = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_mem(input bit pattern);
        logic [15:0] lane;
        for (int i = 0; i < MAX_ROWS; i++) begin
            if (pattern) begin
                for (int k = 0; k < 8; k++) begin
                    lane = (k % 2 == 0) ? 16'(10 * (i + 1)) : 16'(-10 * (i + 1));
                    mem[i][k*16 +: 16] = lane;
                end
            end else begin
                mem[i] = rnd_row();
            end
        end
    endtask

    task automatic issue_start(input int n_req, output int s, output int n);
        n = (n_req > MAX_ROWS) ? MAX_ROWS : n_req;
        @(posedge clk); #1;
        start = 1'b1;
        num_rows = 5'(n_req);
        s = cyc;
        done_seen = 0;
        model_job(s, n);
        job_s = s;
        job_l = latency(n);
        job_active = 1;
        @(posedge clk); #1;
        start = 1'b0;
        num_rows = 5'($urandom_range(0, 31));
    endtask

    task automatic run_job(input int n_req, input bit pattern, input bit repulse);
        int s, n, k;
        fill_mem(pattern);
        issue_start(n_req, s, n);
        if (repulse) begin
            k = 0;
            while (cyc < s + n + 2 + ACC_GAP + 2 && k < 200) begin
                @(posedge clk); #1; k++;
            end
            start = 1'b1;
            num_rows = 5'd5;
            @(posedge clk); #1;
            start = 1'b0;
        end
        k = 0;
        while (!done_seen && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (!done_seen) check("done_timeout", 0, 1);
        else check("job_latency", done_cyc - s, latency(n));
        @(posedge clk); #1;
        check("leftover_events",
              exp_rd_q.size() + exp_acc_q.size() + exp_div_q.size() +
              exp_wr_q.size() + exp_done_q.size(), 0);
        job_active = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},    {127'd0, busy}, '0);
        check({tag, "_done"},    {127'd0, done}, '0);
        check({tag, "_pmem_rd"}, {127'd0, pmem_rd}, '0);
        check({tag, "_acc"},     {127'd0, acc}, '0);
        check({tag, "_div"},     {127'd0, div}, '0);
        check({tag, "_omem_wr"}, {127'd0, omem_wr}, '0);
        check({tag, "_sfp_in"},  sfp_in, '0);
        check({tag, "_omem_data"}, omem_data, '0);
    endtask

    task automatic abort_job(input int n_req);
        int s, n;
        fill_mem(0);
        issue_start(n_req, s, n);
        while (cyc < s + 3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        flush_model();
        check_outputs_zero("abort");
        reset = 1'b0;
        done_seen = 0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", {127'd0, done_seen}, '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);

        run_job(4, 1, 0);
        run_job(16, 0, 0);
        run_job(0, 0, 0);
        run_job(3, 0, 1);
        abort_job(8);
        run_job(2, 0, 0);
        run_job(20, 0, 0);
        for (int t = 0; t < 6; t++) run_job($urandom_range(1, MAX_ROWS), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
